// File: rtl/pwm_pkg.sv
// Shared types and constants for the PWM run controller and its timebase.
package pwm_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } pwm_run_state_t;

    localparam int unsigned DEFAULT_PERIOD_CYCLES = 5000;

endpackage

// File: rtl/pwm_shadow_reg.sv
// Double-buffered period/duty config: valid/ready capture into a shadow,
// commit to the active registers when the controller allows it.
module pwm_shadow_reg #(
    parameter int unsigned CNT_WIDTH             = 32,
    parameter int unsigned DEFAULT_PERIOD_CYCLES = 5000
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 cfg_valid,
    output logic                 cfg_ready,
    input  logic [CNT_WIDTH-1:0] cfg_period,
    input  logic [CNT_WIDTH-1:0] cfg_duty,
    input  logic                 commit_en,
    output logic [CNT_WIDTH-1:0] period,
    output logic [CNT_WIDTH-1:0] duty,
    output logic                 update_applied
);

    logic                 pending_q, pending_d;
    logic [CNT_WIDTH-1:0] sh_period_q, sh_period_d;
    logic [CNT_WIDTH-1:0] sh_duty_q, sh_duty_d;
    logic [CNT_WIDTH-1:0] period_q, period_d;
    logic [CNT_WIDTH-1:0] duty_q, duty_d;
    logic                 update_applied_q, update_applied_d;
    logic                 capture, commit;

    assign cfg_ready = !pending_q;
    // pending gates capture, so capture and commit are mutually exclusive
    assign capture   = cfg_valid && !pending_q;
    assign commit    = pending_q && commit_en;

    always_comb begin
        pending_d        = pending_q;
        sh_period_d      = sh_period_q;
        sh_duty_d        = sh_duty_q;
        period_d         = period_q;
        duty_d           = duty_q;
        update_applied_d = commit;
        if (capture) begin
            pending_d   = 1'b1;
            sh_period_d = cfg_period;
            sh_duty_d   = cfg_duty;
        end else if (commit) begin
            pending_d = 1'b0;
            period_d  = sh_period_q;
            duty_d    = (sh_duty_q > sh_period_q) ? sh_period_q : sh_duty_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_q        <= 1'b0;
            sh_period_q      <= '0;
            sh_duty_q        <= '0;
            period_q         <= CNT_WIDTH'(DEFAULT_PERIOD_CYCLES);
            duty_q           <= '0;
            update_applied_q <= 1'b0;
        end else begin
            pending_q        <= pending_d;
            sh_period_q      <= sh_period_d;
            sh_duty_q        <= sh_duty_d;
            period_q         <= period_d;
            duty_q           <= duty_d;
            update_applied_q <= update_applied_d;
        end
    end

    assign period         = period_q;
    assign duty           = duty_q;
    assign update_applied = update_applied_q;

endmodule

// File: rtl/pwm_run_ctrl.sv
// Run sequencer in front of one PWM timebase: run/burst/stop/abort FSM,
// period counter, and boundary-synchronous config commit.
module pwm_run_ctrl #(
    parameter int unsigned CNT_WIDTH             = 32,
    parameter int unsigned DEFAULT_PERIOD_CYCLES = pwm_pkg::DEFAULT_PERIOD_CYCLES,
    parameter int unsigned BURST_WIDTH           = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   cfg_valid,
    output logic                   cfg_ready,
    input  logic [CNT_WIDTH-1:0]   cfg_period,
    input  logic [CNT_WIDTH-1:0]   cfg_duty,
    input  logic                   start,
    input  logic                   stop,
    input  logic                   abort,
    input  logic [BURST_WIDTH-1:0] burst_len,
    input  logic                   tb_period_end,
    output logic                   tb_enable,
    output logic [CNT_WIDTH-1:0]   tb_period_cycles,
    output logic [CNT_WIDTH-1:0]   duty_cycles,
    output logic                   busy,
    output logic                   done,
    output logic                   update_applied,
    output logic [BURST_WIDTH-1:0] periods_done
);

    import pwm_pkg::*;

    pwm_run_state_t         state_q, state_d;
    logic                   tb_enable_q, tb_enable_d;
    logic                   done_q, done_d;
    logic [BURST_WIDTH-1:0] periods_done_q, periods_done_d;
    logic [BURST_WIDTH-1:0] burst_q, burst_d;
    logic [BURST_WIDTH-1:0] periods_inc;
    logic                   last_period;

    assign periods_inc = (&periods_done_q) ? periods_done_q : periods_done_q + 1'b1;
    // widened compare so a saturated counter never wraps into a false match
    assign last_period = (burst_q != '0) &&
                         ((BURST_WIDTH+1)'(periods_done_q) + 1'b1 == (BURST_WIDTH+1)'(burst_q));

    always_comb begin
        state_d        = state_q;
        done_d         = 1'b0;
        periods_done_d = periods_done_q;
        burst_d        = burst_q;
        case (state_q)
            IDLE: begin
                if (!abort && start) begin
                    state_d        = RUN;
                    periods_done_d = '0;
                    burst_d        = burst_len;
                end
            end
            RUN: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (tb_period_end) begin
                    periods_done_d = periods_inc;
                    if (last_period) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else if (stop) begin
                        state_d = DRAIN;
                    end
                end else if (stop) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (tb_period_end) begin
                    state_d        = IDLE;
                    done_d         = 1'b1;
                    periods_done_d = periods_inc;
                end
            end
            default: state_d = IDLE;
        endcase
        tb_enable_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            tb_enable_q    <= 1'b0;
            done_q         <= 1'b0;
            periods_done_q <= '0;
            burst_q        <= '0;
        end else begin
            state_q        <= state_d;
            tb_enable_q    <= tb_enable_d;
            done_q         <= done_d;
            periods_done_q <= periods_done_d;
            burst_q        <= burst_d;
        end
    end

    assign tb_enable    = tb_enable_q;
    assign busy         = (state_q != IDLE);
    assign done         = done_q;
    assign periods_done = periods_done_q;

    pwm_shadow_reg #(
        .CNT_WIDTH            (CNT_WIDTH),
        .DEFAULT_PERIOD_CYCLES(DEFAULT_PERIOD_CYCLES)
    ) u_shadow (
        .clk           (clk),
        .rst_n         (rst_n),
        .cfg_valid     (cfg_valid),
        .cfg_ready     (cfg_ready),
        .cfg_period    (cfg_period),
        .cfg_duty      (cfg_duty),
        .commit_en     ((state_q == IDLE) || tb_period_end),
        .period        (tb_period_cycles),
        .duty          (duty_cycles),
        .update_applied(update_applied)
    );

endmodule

// File: tb/tb_pwm_run_ctrl.sv
// Directed bench for pwm_run_ctrl: queued expectations for update/done pulses,
// checked by an independent monitor, plus level checks from the stimulus.
module tb_pwm_run_ctrl;

    localparam int CW = 32;
    localparam int BW = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          cfg_valid = 1'b0;
    logic          cfg_ready;
    logic [CW-1:0] cfg_period = '0;
    logic [CW-1:0] cfg_duty = '0;
    logic          start = 1'b0, stop = 1'b0, abort = 1'b0;
    logic [BW-1:0] burst_len = '0;
    logic          tb_period_end = 1'b0;
    logic          tb_enable;
    logic [CW-1:0] tb_period_cycles, duty_cycles;
    logic          busy, done, update_applied;
    logic [BW-1:0] periods_done;

    typedef struct {
        logic [CW-1:0] period;
        logic [CW-1:0] duty;
    } upd_exp_t;

    upd_exp_t      upd_q[$];
    logic [BW-1:0] done_q[$];
    int            n_pass = 0;
    int            n_total = 0;

    pwm_run_ctrl #(.CNT_WIDTH(CW), .DEFAULT_PERIOD_CYCLES(5000), .BURST_WIDTH(BW)) dut (
        .clk(clk), .rst_n(rst_n),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_period(cfg_period), .cfg_duty(cfg_duty),
        .start(start), .stop(stop), .abort(abort), .burst_len(burst_len),
        .tb_period_end(tb_period_end), .tb_enable(tb_enable),
        .tb_period_cycles(tb_period_cycles), .duty_cycles(duty_cycles),
        .busy(busy), .done(done), .update_applied(update_applied),
        .periods_done(periods_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic pend();
        tb_period_end = 1'b1;
        cyc();
        tb_period_end = 1'b0;
    endtask

    task automatic write_cfg(input logic [CW-1:0] p, input logic [CW-1:0] d);
        cfg_valid  = 1'b1;
        cfg_period = p;
        cfg_duty   = d;
        cyc();
        cfg_valid  = 1'b0;
    endtask

    // Monitor: every output pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (rst_n) begin
            if (update_applied) begin
                if (upd_q.size() == 0) begin
                    chk("upd_unexpected", 32'd1, 32'd0);
                end else begin
                    upd_exp_t e;
                    e = upd_q.pop_front();
                    chk("upd_period", tb_period_cycles, e.period);
                    chk("upd_duty", duty_cycles, e.duty);
                    chk("upd_cfg_ready", 32'(cfg_ready), 32'd1);
                end
            end
            if (done) begin
                if (done_q.size() == 0) begin
                    chk("done_unexpected", 32'd1, 32'd0);
                end else begin
                    logic [BW-1:0] pd;
                    pd = done_q.pop_front();
                    chk("done_periods", 32'(periods_done), 32'(pd));
                    chk("done_tb_enable", 32'(tb_enable), 32'd0);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        cyc(); cyc();
        rst_n = 1'b1;
        cyc();
        chk("rst_tb_enable", 32'(tb_enable), 32'd0);
        chk("rst_period", tb_period_cycles, 32'd5000);
        chk("rst_duty", duty_cycles, 32'd0);
        chk("rst_cfg_ready", 32'(cfg_ready), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_periods", 32'(periods_done), 32'd0);

        // idle write commits on the following cycle
        write_cfg(10, 4);
        chk("idle_pending_ready", 32'(cfg_ready), 32'd0);
        upd_q.push_back('{period: 10, duty: 4});
        cyc(); cyc();

        // burst of 3
        burst_len = 3; start = 1'b1; cyc(); start = 1'b0;
        chk("burst_tb_enable", 32'(tb_enable), 32'd1);
        pend(); cyc();
        pend(); cyc();
        chk("burst_mid_periods", 32'(periods_done), 32'd2);
        chk("burst_mid_busy", 32'(busy), 32'd1);
        done_q.push_back(3);
        pend();
        chk("burst_end_busy", 32'(busy), 32'd0);
        cyc(); cyc();

        // continuous run with mid-period write and duty clamp
        burst_len = 0; start = 1'b1; cyc(); start = 1'b0;
        pend(); cyc();
        write_cfg(20, 25);
        cyc(); cyc();
        chk("run_pending_ready", 32'(cfg_ready), 32'd0);
        chk("run_period_held", tb_period_cycles, 32'd10);
        upd_q.push_back('{period: 20, duty: 20});
        pend();
        chk("run_busy_after_commit", 32'(busy), 32'd1);

        // graceful stop drains the current period
        stop = 1'b1; cyc(); stop = 1'b0;
        cyc();
        chk("drain_tb_enable", 32'(tb_enable), 32'd1);
        done_q.push_back(3);
        pend();
        chk("drain_end_tb_enable", 32'(tb_enable), 32'd0);
        cyc(); cyc();

        // abort with a pending shadow: no done, shadow commits in idle
        start = 1'b1; cyc(); start = 1'b0;
        pend();
        write_cfg(30, 7);
        chk("abort_pending_ready", 32'(cfg_ready), 32'd0);
        upd_q.push_back('{period: 30, duty: 7});
        abort = 1'b1; cyc(); abort = 1'b0;
        chk("abort_tb_enable", 32'(tb_enable), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_no_done", 32'(done), 32'd0);
        cyc(); cyc();

        // abort beats start in idle
        start = 1'b1; abort = 1'b1; cyc(); start = 1'b0; abort = 1'b0;
        chk("abort_start_busy", 32'(busy), 32'd0);
        chk("abort_start_tb_enable", 32'(tb_enable), 32'd0);

        // burst of 2: start while busy ignored, stop coincides with last period
        burst_len = 2; start = 1'b1; cyc(); start = 1'b0;
        pend();
        burst_len = 0; start = 1'b1; cyc(); start = 1'b0;
        chk("restart_ignored_periods", 32'(periods_done), 32'd1);
        done_q.push_back(2);
        stop = 1'b1; tb_period_end = 1'b1; cyc(); stop = 1'b0; tb_period_end = 1'b0;
        chk("stop_last_busy", 32'(busy), 32'd0);
        chk("stop_last_periods", 32'(periods_done), 32'd2);
        cyc(); cyc();

        // period_end in idle is ignored
        pend();
        chk("idle_pend_periods", 32'(periods_done), 32'd2);
        chk("idle_pend_busy", 32'(busy), 32'd0);

        // reset mid-run discards the shadow
        start = 1'b1; cyc(); start = 1'b0;
        pend();
        write_cfg(40, 1);
        rst_n = 1'b0; cyc(); rst_n = 1'b1;
        cyc();
        chk("rst2_tb_enable", 32'(tb_enable), 32'd0);
        chk("rst2_period", tb_period_cycles, 32'd5000);
        chk("rst2_duty", duty_cycles, 32'd0);
        chk("rst2_cfg_ready", 32'(cfg_ready), 32'd1);
        chk("rst2_periods", 32'(periods_done), 32'd0);
        chk("rst2_busy", 32'(busy), 32'd0);
        cyc(); cyc(); cyc();

        chk("upd_queue_drained", 32'(upd_q.size()), 32'd0);
        chk("done_queue_drained", 32'(done_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/pwm_run_ctrl.md
Name: pwm_run_ctrl

Overview:
- Sequencing and configuration controller that sits directly in front of one PWM timebase instance and its compare stage.
- Owns the timebase enable and the active period/duty registers.
- Double-buffers software config writes and commits them only on period boundaries; supports continuous run, N-period burst, graceful stop and immediate abort.
- Software CSR block drives the cfg/command side; the timebase and compare logic consume the tb_/duty outputs.

Parameters:
- CNT_WIDTH, 32, width of period/duty values (matches timebase counter width).
- DEFAULT_PERIOD_CYCLES, 5000, active period after reset.
- BURST_WIDTH, 16, width of burst length and period counter.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous reset, active-low
- cfg_valid  in  1  new period/duty offered
- cfg_ready  out  1  shadow register free to accept
- cfg_period  in  CNT_WIDTH  requested period in clk cycles
- cfg_duty  in  CNT_WIDTH  requested high time in clk cycles
- start  in  1  single-cycle run command
- stop  in  1  single-cycle graceful stop (finish current period)
- abort  in  1  single-cycle immediate stop
- burst_len  in  BURST_WIDTH  periods to run per start; 0 = continuous; sampled at start
- tb_period_end  in  1  period_end pulse from timebase
- tb_enable  out  1  timebase enable
- tb_period_cycles  out  CNT_WIDTH  active period to timebase
- duty_cycles  out  CNT_WIDTH  active duty to compare stage
- busy  out  1  state != IDLE
- done  out  1  one-cycle pulse on normal completion
- update_applied  out  1  one-cycle pulse when shadow committed
- periods_done  out  BURST_WIDTH  completed periods since last start

Behaviour:
- Reset values:
  - State IDLE; tb_enable=0.
  - tb_period_cycles=DEFAULT_PERIOD_CYCLES; duty_cycles=0.
  - Shadow empty, so cfg_ready=1.
  - done=0, update_applied=0, periods_done=0, latched burst=0.
- Shadow handshake:
  - Transfer when cfg_valid && cfg_ready; shadow captures period/duty and sets pending.
  - cfg_ready = !pending (combinational from the flag).
  - Pending blocks further writes until commit; cfg_valid with cfg_ready=0 is not captured, and the source must hold it.
- Commit:
  - Shadow copied to active registers, pending cleared, update_applied pulsed next cycle.
  - In IDLE: commit on the cycle after capture.
  - In RUN/DRAIN: commit only on a cycle with tb_period_end=1.
  - Capture and commit never happen in the same cycle (pending blocks capture).
- Duty clamp: duty_cycles = min(shadow duty, shadow period) at commit time. Period value is passed through unclamped; the timebase handles 0/1.
- FSM transitions (priority abort > stop > start, one command per cycle):
  - IDLE + start -> RUN. Registered tb_enable=1 from the next cycle; periods_done cleared; burst_len latched.
  - RUN + tb_period_end:
    - periods_done++ (saturating).
    - If latched burst != 0 and periods_done+1 == burst -> IDLE, tb_enable=0 next cycle, done pulse.
  - RUN + stop -> DRAIN. DRAIN + tb_period_end -> IDLE, done pulse, periods_done++.
  - Any state + abort -> IDLE next cycle, tb_enable=0, no done pulse.
  - Abort does not discard pending shadow; that shadow commits in IDLE.
- Commands with no effect:
  - start while busy: ignored.
  - stop while IDLE or DRAIN: ignored.
  - stop on the same cycle as burst-terminating tb_period_end: burst completion wins, one done pulse.
- tb_period_end while IDLE: ignored.
- Reset asserted mid-operation: all state returns to reset values; shadow discarded.

Decomposition:
- Package pwm_pkg:
  - typedef enum logic [1:0] pwm_run_state_t {IDLE, RUN, DRAIN}.
  - Constant DEFAULT_PERIOD_CYCLES shared with the timebase.
- Sub-module pwm_shadow_reg: valid/ready capture, pending flag, commit strobe, duty clamp.
- FSM and period counter stay in the top.

Test Plan:
- Reset then idle: tb_enable=0, tb_period_cycles=5000, duty_cycles=0, cfg_ready=1.
- Write period=10, duty=4 in IDLE -> update_applied one cycle later; active 10/4; cfg_ready back to 1.
- start with burst_len=3, timebase driven -> exactly 3 tb_period_end pulses, then tb_enable=0, done=1 for one cycle, periods_done=3.
- Continuous run; write period=20, duty=25 mid-period -> cfg_ready=0 until next tb_period_end; then active 20/20 (duty clamped), update_applied pulse.
- stop mid-period -> tb_enable stays 1 until tb_period_end, then 0, done pulse. Abort mid-period -> tb_enable=0 next cycle, no done.
- Simultaneous abort+start in IDLE and stop+final burst tb_period_end -> IDLE with no run / exactly one done pulse; rst_n low mid-RUN -> all reset values.
